// File: rtl/light_sched_pkg.sv
// Shared definitions for the key-light scheduler: rest codes, requester IDs,
// scheduler state encoding and a code classification helper.
// Optional feature macro used by this codebase: LIGHT_SCHED_CHASE_EN.
package light_sched_pkg;

    // Note codes that mean "rest": accepted, but they drive no light.
    localparam logic [7:0] REST_CODE_LO = 8'd0;
    localparam logic [7:0] REST_CODE_HI = 8'd99;

    // Requester identity, also the encoding of oGrant.
    typedef enum logic {
        REQ_KEY  = 1'b0,
        REQ_PLAY = 1'b1
    } req_id_t;

    // Scheduler state. ST_CHASE is only reachable when the chase pattern is built in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CHASE  = 2'd2
    } sched_state_t;

    function automatic logic is_rest(input logic [7:0] code);
        return (code == REST_CODE_LO) || (code == REST_CODE_HI);
    endfunction

endpackage

// File: rtl/light_scheduler_if.sv
// Note handshake bundle between the two note sources (keyboard, autoplay)
// and the light scheduler.
//
// Handshake: a transfer completes on a rising edge where valid and ready are
// both high. A source raises valid with a stable note and keeps both unchanged
// until that edge. Ready is combinational from both valids and the arbitration
// pointer; at most one ready is high in any cycle, and both are low in reset.
interface light_scheduler_if;
    logic [7:0] iKeyNote;
    logic       iKeyValid;
    logic       oKeyReady;
    logic [7:0] iPlayNote;
    logic       iPlayValid;
    logic       oPlayReady;

    modport master (
        output iKeyNote, iKeyValid, iPlayNote, iPlayValid,
        input  oKeyReady, oPlayReady
    );

    modport slave (
        input  iKeyNote, iKeyValid, iPlayNote, iPlayValid,
        output oKeyReady, oPlayReady
    );
endinterface

// File: rtl/light_hold_timer.sv
// Per-light hold timer: a load sets the count to HOLD_CYCLES, the count then
// falls by one per cycle and the light is on while the count is nonzero.
// A load in the final on-cycle reloads without a gap.
module light_hold_timer #(
    parameter int HOLD_CYCLES = 24
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic load_i,
    output logic on_o,
    output logic busy_next_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    // Load takes priority over the countdown so a re-trigger always restarts the hold.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CNT_W'(HOLD_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign on_o        = (count_q != '0);
    // Light will still be on next cycle: lets the scheduler pick its next state.
    assign busy_next_o = load_i || (count_q > CNT_W'(1));

endmodule

// File: rtl/light_scheduler.sv
// Key-light scheduler: round-robin arbitration between keyboard and autoplay
// note sources, note-to-light decode, per-light hold timing and state tracking.
// Optional feature macro: LIGHT_SCHED_CHASE_EN adds an idle chase pattern.
module light_scheduler
    import light_sched_pkg::*;
#(
    parameter int NUM_LIGHTS  = 8,
    parameter int HOLD_CYCLES = 24,
    parameter int IDLE_CYCLES = 1000,
    parameter int CHASE_STEP  = 50
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    light_scheduler_if.slave      bus,
    output logic [NUM_LIGHTS-1:0] oLights,
    output logic                  oGrant,
    output logic                  oDropErr,
    output sched_state_t          oState
);

    if (NUM_LIGHTS < 1 || NUM_LIGHTS > 16 || HOLD_CYCLES < 2 ||
        IDLE_CYCLES < 1 || CHASE_STEP < 1) begin : g_param_check
        $error("light_scheduler: parameter out of range");
    end

    sched_state_t          state_q;
    req_id_t               prio_q;
    req_id_t               grant_q;
    logic                  drop_q;
    logic                  key_ready;
    logic                  play_ready;
    logic                  accept;
    req_id_t               grant_id;
    logic [7:0]            sel_note;
    logic                  code_bad;
    logic [NUM_LIGHTS-1:0] load_vec;
    logic [NUM_LIGHTS-1:0] hold_on;
    logic [NUM_LIGHTS-1:0] busy_next;
    logic                  any_busy_d;

    // Arbitration: a lone requester wins at once; on contention prio_q decides.
    always_comb begin
        key_ready  = iReset_n && bus.iKeyValid  && (!bus.iPlayValid || prio_q == REQ_KEY);
        play_ready = iReset_n && bus.iPlayValid && (!bus.iKeyValid  || prio_q == REQ_PLAY);
        accept     = key_ready || play_ready;
        grant_id   = play_ready ? REQ_PLAY : REQ_KEY;
        sel_note   = play_ready ? bus.iPlayNote : bus.iKeyNote;
    end

    assign bus.oKeyReady  = key_ready;
    assign bus.oPlayReady = play_ready;

    // Decode the accepted note: 1..NUM_LIGHTS loads light code-1, rests are ignored,
    // anything else is an out-of-range drop.
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            load_vec[i] = accept && (sel_note == 8'(i + 1));
        end
        code_bad = accept && !is_rest(sel_note) &&
                   ((sel_note == 8'd0) || (sel_note > 8'(NUM_LIGHTS)));
    end

    for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_timer
        light_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_timer (
            .iClk        (iClk),
            .iReset_n    (iReset_n),
            .load_i      (load_vec[g]),
            .on_o        (hold_on[g]),
            .busy_next_o (busy_next[g])
        );
    end

    assign any_busy_d = |busy_next;

`ifdef LIGHT_SCHED_CHASE_EN
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int STEP_W = $clog2(CHASE_STEP + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CHASE_STEP - 1);

    logic [IDLE_W-1:0]     idle_cnt_q;
    logic [STEP_W-1:0]     step_cnt_q;
    logic [NUM_LIGHTS-1:0] chase_q;

    // Scheduler FSM with grant/drop outputs and the idle chase counters.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q    <= ST_IDLE;
            prio_q     <= REQ_KEY;
            grant_q    <= REQ_KEY;
            drop_q     <= 1'b0;
            idle_cnt_q <= '0;
            step_cnt_q <= '0;
            chase_q    <= '0;
        end else begin
            drop_q <= code_bad;
            if (accept) begin
                grant_q <= grant_id;
                prio_q  <= (grant_id == REQ_KEY) ? REQ_PLAY : REQ_KEY;
            end
            case (state_q)
                ST_CHASE: begin
                    if (accept) begin
                        chase_q    <= '0;
                        step_cnt_q <= '0;
                        idle_cnt_q <= '0;
                        state_q    <= any_busy_d ? ST_ACTIVE : ST_IDLE;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_q <= '0;
                        chase_q    <= (chase_q << 1) | (chase_q >> (NUM_LIGHTS - 1));
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                default: begin
                    state_q <= any_busy_d ? ST_ACTIVE : ST_IDLE;
                    if (state_q == ST_IDLE && !accept) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_q    <= ST_CHASE;
                            chase_q    <= NUM_LIGHTS'(1);
                            idle_cnt_q <= '0;
                            step_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign oLights = hold_on | chase_q;
`else
    // Scheduler FSM with grant/drop outputs.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q <= ST_IDLE;
            prio_q  <= REQ_KEY;
            grant_q <= REQ_KEY;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= code_bad;
            if (accept) begin
                grant_q <= grant_id;
                prio_q  <= (grant_id == REQ_KEY) ? REQ_PLAY : REQ_KEY;
            end
            state_q <= any_busy_d ? ST_ACTIVE : ST_IDLE;
        end
    end

    assign oLights = hold_on;
`endif

    assign oGrant   = grant_q;
    assign oDropErr = drop_q;
    assign oState   = state_q;

endmodule
